candy_dispense_seq: RTL and testbench
=====================================

Name: candy_dispense_seq

Overview:
- Parametrised multi-channel dispense sequencer. It is the next generation of the single-hopper candy dispense control.
- It takes a dispense request from the Raspberry Pi (candyflag, amount, channel select) and runs a spin-up phase followed by a metered stepper phase.
- It drives the selected DC agitator motor and the shared stepper, then returns a handshake.
- It sits between the Pi GPIO inputs and the motor driver pins inside project_module.

Parameters:
NUM_CH, 3, number of dispense channels / DC motors (1..8)
AMT_W, 2, width of amount input; units dispensed = amount+1
STEPS_PER_UNIT, 200, stepper steps per dispensed unit
STEP_HALF, 6000, clk_x1 cycles per step half-period (high and low each)
SPIN_CYCLES, 120000, clk_x1 cycles of DC spin-up before stepping
STEP_DIR, 1, stepperdir level during STEP phase

Ports:
clk_x1  in  1  12 MHz system clock
rst  in  1  synchronous, active-high reset
candyflag  in  1  dispense request level from Pi; acted on at rising edge
amount  in  AMT_W  units-1 to dispense; latched at request
chan_sel  in  CH_W  channel index; CH_W = max(1,clog2(NUM_CH)); latched at request
stepperstep  out  1  stepper step pulse
stepperdir  out  1  stepper direction
dcmotor  out  NUM_CH  one-hot DC motor enables
handshake  out  1  dispense complete, held until candyflag low
busy  out  1  high in SPIN/STEP/DONE
err  out  1  one-cycle pulse on invalid channel request

Behaviour:
- Clock and reset: single clock clk_x1. rst is synchronous and active-high. All state updates on the rising edge of clk_x1.
- Reset values: all outputs 0, FSM in IDLE, flag_q=0, all counters 0.
- Reset mid-operation: the same reset values apply in the cycle after rst is sampled. There is no partial resume.
- Edge detect: flag_q registers candyflag. req = candyflag & ~flag_q.
- State IDLE:
  - On req with chan_sel < NUM_CH: latch amount and chan_sel, go to SPIN next cycle.
  - On req with chan_sel >= NUM_CH: err=1 for exactly one cycle, stay in IDLE, motors untouched.
- State SPIN:
  - dcmotor = 1<<ch. This output is registered and asserts in the first SPIN cycle, i.e. 1 cycle after req is sampled.
  - Stays in SPIN for exactly SPIN_CYCLES cycles, then goes to STEP.
- State STEP:
  - dcmotor stays asserted; stepperdir = STEP_DIR.
  - Issues total = (amount+1)*STEPS_PER_UNIT pulses. Each pulse is STEP_HALF cycles high then STEP_HALF cycles low; the first high starts in the first STEP cycle.
  - Step counter width is sized for the maximum total; no wrap-around.
  - After the last low half-period, goes to DONE with dcmotor=0, stepperstep=0, stepperdir=0.
- State DONE:
  - handshake=1 and busy=1.
  - When candyflag is sampled low, go to IDLE; handshake drops in that transition cycle.
- Requests outside IDLE: rising edges of candyflag in SPIN/STEP/DONE are ignored and not queued. amount and chan_sel changes after latch are ignored.
- Simultaneous rst and req: rst wins.
- Output cleanliness: dcmotor is never multi-hot. stepperstep is 0 outside STEP.

Optional Feature:
- Macro: DISPENSE_TALLY_EN.
- When defined: an extra output port tally (16 bits, reset 0). tally increments by amount+1 on each DONE entry and saturates at 16'hFFFF.
- When not defined: no tally port or counter logic exists; all other behaviour is identical.

Test Plan:
All scenarios use NUM_CH=3, AMT_W=2, STEPS_PER_UNIT=4, STEP_HALF=2, SPIN_CYCLES=5.
1. rst 1→0; amount=0, chan_sel=0, candyflag 0→1 → dcmotor=3'b001 for 5 cycles; then 4 stepperstep pulses (2 high/2 low), dcmotor still 3'b001, stepperdir=1; then handshake=1 and busy=1 until candyflag=0; total active time 5+16 cycles.
2. amount=3, chan_sel=2 → dcmotor=3'b100, 16 pulses (64 STEP cycles), handshake afterwards; dcmotor[1:0] stay 0 throughout.
3. chan_sel=3 with candyflag rising → err high exactly 1 cycle, busy=0, no motor or step activity.
4. rst pulsed during STEP after 2 pulses → next cycle all outputs 0, FSM IDLE; a new request then produces the full pulse count from zero.
5. candyflag toggled 1→0→1 during STEP, then held high past DONE → no extra dispense; handshake held; after candyflag=0 → IDLE; the next rising edge starts a new run.
6. With DISPENSE_TALLY_EN defined, run scenario 1 then scenario 2 → tally = 1 then 5; tally=0 after rst.

Source files
------------

// File: rtl/candy_dispense_seq.sv
// candy_dispense_seq: multi-channel candy dispense sequencer.
// A rising edge on candyflag starts a run on the selected channel. The run has
// two phases: a DC agitator spin-up, then a metered stepper phase of
// (amount+1)*STEPS_PER_UNIT pulses. The sequencer then holds handshake high
// until candyflag returns low.
// Optional feature: define DISPENSE_TALLY_EN to add the 16-bit saturating
// `tally` output, which counts the units dispensed.
module candy_dispense_seq #(
  parameter int NUM_CH         = 3,
  parameter int AMT_W          = 2,
  parameter int STEPS_PER_UNIT = 200,
  parameter int STEP_HALF      = 6000,
  parameter int SPIN_CYCLES    = 120000,
  parameter bit STEP_DIR       = 1'b1,
  localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_x1,
  input  logic              rst,
  input  logic              candyflag,
  input  logic [AMT_W-1:0]  amount,
  input  logic [CH_W-1:0]   chan_sel,
  output logic              stepperstep,
  output logic              stepperdir,
  output logic [NUM_CH-1:0] dcmotor,
  output logic              handshake,
  output logic              busy,
  output logic              err
`ifdef DISPENSE_TALLY_EN
  ,
  output logic [15:0]       tally
`endif
);

  // One timer serves both the spin-up phase and each step half-period.
  localparam int TMR_MAX   = (SPIN_CYCLES > STEP_HALF) ? SPIN_CYCLES : STEP_HALF;
  localparam int TMR_W     = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  // The pulse counter only has to reach the largest possible total minus one.
  localparam int MAX_TOTAL = (2 ** AMT_W) * STEPS_PER_UNIT;
  localparam int STEP_W    = (MAX_TOTAL > 1) ? $clog2(MAX_TOTAL) : 1;

  typedef enum logic [1:0] {IDLE, SPIN, STEP, DONE} state_t;

  state_t            state;
  logic              flag_q;
  logic [TMR_W-1:0]  tmr;
  logic [STEP_W-1:0] step_cnt;
  logic [STEP_W-1:0] last_step;

  logic req;
  logic chan_ok;
  logic start;
  logic spin_end;
  logic half_end;
  logic done_entry;

  assign req        = candyflag & ~flag_q;
  assign chan_ok    = int'(chan_sel) < NUM_CH;
  assign start      = (state == IDLE) && req && chan_ok;
  assign spin_end   = tmr == TMR_W'(SPIN_CYCLES - 1);
  assign half_end   = tmr == TMR_W'(STEP_HALF - 1);
  // The last low half-period of the final pulse has just ended.
  assign done_entry = (state == STEP) && half_end && !stepperstep && (step_cnt == last_step);

  // Sequencer FSM: every output is a register, so no combinational glitches reach the drivers.
  always_ff @(posedge clk_x1) begin
    // NOTE: sequential state uses non-blocking (<=) so that every register samples pre-edge values, whatever the statement order.
    if (rst) begin
      state       <= IDLE;
      flag_q      <= 1'b0;
      tmr         <= '0;
      step_cnt    <= '0;
      last_step   <= '0;
      stepperstep <= 1'b0;
      stepperdir  <= 1'b0;
      dcmotor     <= '0;
      handshake   <= 1'b0;
      busy        <= 1'b0;
      err         <= 1'b0;
    end else begin
      flag_q <= candyflag;
      err    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req) begin
            if (chan_ok) begin
              state     <= SPIN;
              dcmotor   <= NUM_CH'(1) << chan_sel;
              busy      <= 1'b1;
              tmr       <= '0;
              step_cnt  <= '0;
              last_step <= STEP_W'((int'(amount) + 1) * STEPS_PER_UNIT - 1);
            end else begin
              err <= 1'b1;
            end
          end
        end
        SPIN: begin
          if (spin_end) begin
            state       <= STEP;
            tmr         <= '0;
            stepperstep <= 1'b1;
            stepperdir  <= STEP_DIR;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        STEP: begin
          if (half_end) begin
            tmr <= '0;
            if (stepperstep) begin
              stepperstep <= 1'b0;
            end else if (done_entry) begin
              state      <= DONE;
              dcmotor    <= '0;
              stepperdir <= 1'b0;
              handshake  <= 1'b1;
            end else begin
              step_cnt    <= step_cnt + 1'b1;
              stepperstep <= 1'b1;
            end
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        DONE: begin
          if (!candyflag) begin
            state     <= IDLE;
            handshake <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DISPENSE_TALLY_EN
  logic [AMT_W-1:0] amt_q;
  logic [16:0]      tally_sum;

  assign tally_sum = {1'b0, tally} + 17'(amt_q) + 17'd1;

  // Units tally: latch the amount at request, then add it once on each DONE entry, saturating.
  always_ff @(posedge clk_x1) begin
    if (rst) begin
      amt_q <= '0;
      tally <= '0;
    end else begin
      if (start) amt_q <= amount;
      if (done_entry) tally <= tally_sum[16] ? 16'hFFFF : tally_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_candy_dispense_seq.sv
// Directed testbench for candy_dispense_seq, using the reduced timing set:
// NUM_CH=3, AMT_W=2, STEPS_PER_UNIT=4, STEP_HALF=2, SPIN_CYCLES=5.
// Define DISPENSE_TALLY_EN to also exercise the tally output.
module tb_candy_dispense_seq;
  localparam int NUM_CH = 3;
  localparam int AMT_W  = 2;
  localparam int SPU    = 4;
  localparam int HALF   = 2;
  localparam int SPIN   = 5;

  logic             clk_x1    = 1'b0;
  logic             rst       = 1'b1;
  logic             candyflag = 1'b0;
  logic [AMT_W-1:0] amount    = '0;
  logic [1:0]       chan_sel  = '0;
  logic             stepperstep;
  logic             stepperdir;
  logic [NUM_CH-1:0] dcmotor;
  logic             handshake;
  logic             busy;
  logic             err;
`ifdef DISPENSE_TALLY_EN
  logic [15:0]      tally;
`endif

  int checks = 0;
  int errors = 0;

  candy_dispense_seq #(
    .NUM_CH(NUM_CH), .AMT_W(AMT_W), .STEPS_PER_UNIT(SPU),
    .STEP_HALF(HALF), .SPIN_CYCLES(SPIN), .STEP_DIR(1'b1)
  ) dut (
    .clk_x1(clk_x1), .rst(rst), .candyflag(candyflag), .amount(amount),
    .chan_sel(chan_sel), .stepperstep(stepperstep), .stepperdir(stepperdir),
    .dcmotor(dcmotor), .handshake(handshake), .busy(busy), .err(err)
`ifdef DISPENSE_TALLY_EN
    , .tally(tally)
`endif
  );

  always #5 clk_x1 = ~clk_x1;

  // Observed outputs packed as {dcmotor, stepperstep, stepperdir, busy, handshake, err}.
  logic [7:0] obs;
  assign obs = {dcmotor, stepperstep, stepperdir, busy, handshake, err};

  // Expected output vector k cycles after the edge that samples a valid request.
  function automatic logic [7:0] model(int amt, int ch, int k);
    int         steps = SPU * (amt + 1) * 2 * HALF;
    logic [2:0] m     = 3'(1 << ch);
    if (k < SPIN)         return {m, 5'b00100};
    if (k < SPIN + steps) return {m, (((k - SPIN) % (2 * HALF)) < HALF), 4'b1100};
    return {3'b000, 5'b00110};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk_x1);
    candyflag = 1'b1;  // request coincides with reset: reset must win
    @(negedge clk_x1);
    checks++;
    if (obs !== 8'h00) begin
      errors++;
      $display("FAIL reset_hold got %b exp %b", obs, 8'h00);
    end
`ifdef DISPENSE_TALLY_EN
    checks++;
    if (tally !== 16'd0) begin
      errors++;
      $display("FAIL reset_tally got %0d exp 0", tally);
    end
`endif
    candyflag = 1'b0;
    @(negedge clk_x1);
    rst = 1'b0;
    @(negedge clk_x1);
    checks++;
    if (obs !== 8'h00) begin
      errors++;
      $display("FAIL reset_release got %b exp %b", obs, 8'h00);
    end
  endtask

  task automatic test_single();
    amount = 2'd0; chan_sel = 2'd0;
    @(negedge clk_x1);
    candyflag = 1'b1;
    for (int k = 0; k < SPIN + 16 + 3; k++) begin
      @(negedge clk_x1);
      checks++;
      if (obs !== model(0, 0, k)) begin
        errors++;
        $display("FAIL single k=%0d got %b exp %b", k, obs, model(0, 0, k));
      end
    end
    candyflag = 1'b0;
    @(negedge clk_x1);
    checks++;
    if (obs !== 8'h00) begin
      errors++;
      $display("FAIL single_release got %b exp %b", obs, 8'h00);
    end
`ifdef DISPENSE_TALLY_EN
    checks++;
    if (tally !== 16'd1) begin
      errors++;
      $display("FAIL single_tally got %0d exp 1", tally);
    end
`endif
  endtask

  task automatic test_multi_unit();
    amount = 2'd3; chan_sel = 2'd2;
    @(negedge clk_x1);
    candyflag = 1'b1;
    for (int k = 0; k < SPIN + 64 + 3; k++) begin
      @(negedge clk_x1);
      checks++;
      if (obs !== model(3, 2, k)) begin
        errors++;
        $display("FAIL multi k=%0d got %b exp %b", k, obs, model(3, 2, k));
      end
      // Changing the inputs after the latch must have no effect.
      if (k == 10) begin
        amount = 2'd0; chan_sel = 2'd1;
      end
    end
    candyflag = 1'b0;
    @(negedge clk_x1);
    checks++;
    if (obs !== 8'h00) begin
      errors++;
      $display("FAIL multi_release got %b exp %b", obs, 8'h00);
    end
`ifdef DISPENSE_TALLY_EN
    checks++;
    if (tally !== 16'd5) begin
      errors++;
      $display("FAIL multi_tally got %0d exp 5", tally);
    end
`endif
  endtask

  task automatic test_bad_channel();
    amount = 2'd1; chan_sel = 2'd3;
    @(negedge clk_x1);
    candyflag = 1'b1;
    @(negedge clk_x1);
    checks++;
    if (obs !== 8'b0000_0001) begin
      errors++;
      $display("FAIL bad_chan_err got %b exp %b", obs, 8'b0000_0001);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_x1);
      checks++;
      if (obs !== 8'h00) begin
        errors++;
        $display("FAIL bad_chan_quiet k=%0d got %b exp %b", k, obs, 8'h00);
      end
    end
    candyflag = 1'b0;
    @(negedge clk_x1);
  endtask

  task automatic test_reset_mid_step();
    amount = 2'd1; chan_sel = 2'd1;
    @(negedge clk_x1);
    candyflag = 1'b1;
    // Spin-up plus two complete step pulses.
    for (int k = 0; k < SPIN + 8; k++) begin
      @(negedge clk_x1);
      checks++;
      if (obs !== model(1, 1, k)) begin
        errors++;
        $display("FAIL mid_pre k=%0d got %b exp %b", k, obs, model(1, 1, k));
      end
    end
    rst = 1'b1; candyflag = 1'b0;
    @(negedge clk_x1);
    checks++;
    if (obs !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset got %b exp %b", obs, 8'h00);
    end
`ifdef DISPENSE_TALLY_EN
    checks++;
    if (tally !== 16'd0) begin
      errors++;
      $display("FAIL mid_reset_tally got %0d exp 0", tally);
    end
`endif
    rst = 1'b0;
    @(negedge clk_x1);
    candyflag = 1'b1;
    for (int k = 0; k < SPIN + 32 + 3; k++) begin
      @(negedge clk_x1);
      checks++;
      if (obs !== model(1, 1, k)) begin
        errors++;
        $display("FAIL mid_rerun k=%0d got %b exp %b", k, obs, model(1, 1, k));
      end
    end
    candyflag = 1'b0;
    @(negedge clk_x1);
    checks++;
    if (obs !== 8'h00) begin
      errors++;
      $display("FAIL mid_release got %b exp %b", obs, 8'h00);
    end
  endtask

  task automatic test_retrigger();
    amount = 2'd0; chan_sel = 2'd0;
    @(negedge clk_x1);
    candyflag = 1'b1;
    for (int k = 0; k < SPIN + 16 + 6; k++) begin
      @(negedge clk_x1);
      checks++;
      if (obs !== model(0, 0, k)) begin
        errors++;
        $display("FAIL retrig k=%0d got %b exp %b", k, obs, model(0, 0, k));
      end
      // Toggle the request mid-STEP, then hold it high well past DONE.
      if (k == 7) candyflag = 1'b0;
      if (k == 9) candyflag = 1'b1;
    end
    candyflag = 1'b0;
    @(negedge clk_x1);
    checks++;
    if (obs !== 8'h00) begin
      errors++;
      $display("FAIL retrig_release got %b exp %b", obs, 8'h00);
    end
    // A new rising edge right after returning to IDLE starts a fresh run.
    candyflag = 1'b1;
    for (int k = 0; k < SPIN + 16 + 2; k++) begin
      @(negedge clk_x1);
      checks++;
      if (obs !== model(0, 0, k)) begin
        errors++;
        $display("FAIL retrig_next k=%0d got %b exp %b", k, obs, model(0, 0, k));
      end
    end
    candyflag = 1'b0;
    @(negedge clk_x1);
    checks++;
    if (obs !== 8'h00) begin
      errors++;
      $display("FAIL retrig_next_release got %b exp %b", obs, 8'h00);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi_unit();
    test_bad_channel();
    test_reset_mid_step();
    test_retrigger();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
